// File: rtl/aes_mixcol_addkey.sv
// AES forward MixColumns + AddRoundKey on a 128-bit state, COLS_PER_CYCLE columns per clock.
// Final-round blocks (in_last) skip MixColumns and only XOR the round key.
module aes_mixcol_addkey #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
      $error("aes_mixcol_addkey: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Column counter is 2 bits wide, so a step of 4 wraps straight back to 0.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       st;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic [127:0] key_r;
  logic         last_r;
  logic [127:0] work_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] m0, m1, m2, m3;
    s0 = c[7:0];
    s1 = c[15:8];
    s2 = c[23:16];
    s3 = c[31:24];
    m0 = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    m1 = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    m2 = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    m3 = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
    return {m3, m2, m1, m0};
  endfunction

  always_comb begin
    work_next = work;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(cnt) && i < int'(cnt) + COLS_PER_CYCLE) begin
        work_next[32*i +: 32] = (last_r ? work[32*i +: 32] : mix_col(work[32*i +: 32]))
                                ^ key_r[32*i +: 32];
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a source holds its payload until that edge, and ready never depends on valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      cnt       <= 2'd0;
      work      <= 128'd0;
      key_r     <= 128'd0;
      last_r    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_state;
            key_r    <= in_key;
            last_r   <= in_last;
            cnt      <= 2'd0;
            st       <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          work <= work_next;
          cnt  <= cnt + STEP;
          if (cnt == LAST_CNT) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign out_state = work;

endmodule

// File: tb/tb_aes_mixcol_addkey.sv
// Bench for aes_mixcol_addkey: three instances (1, 2, 4 columns per cycle), directed vectors,
// a GF(2^8) reference model feeding a scoreboard, and a per-cycle compare process.
module tb_aes_mixcol_addkey;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_ready;
  logic         in_valid    [3];
  logic         in_ready_w  [3];
  logic         out_valid_w [3];
  logic         busy_w      [3];
  logic [127:0] out_state_w [3];

  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] V1_S  = 128'h455313db;
  localparam logic [127:0] V1_O  = 128'hbca14d8e;
  localparam logic [127:0] V2_S  = {32'h01010101, 32'hc6c6c6c6, 32'h5c220af2, 32'h455313db};
  localparam logic [127:0] V2_O  = {32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f, 32'hbca14d8e};
  localparam logic [127:0] FI_S  = 128'he598271ef11141b8ae52b4e0305dbfd4;
  localparam logic [127:0] FI_K  = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] FI_O  = 128'h49506a0243ea5b6b2b359f68f27f9ca4;
  localparam logic [127:0] LA_S  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] LA_O  = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] ONES  = {128{1'b1}};

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      aes_mixcol_addkey #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready_w[g]),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid_w[g]),
        .out_ready (out_ready),
        .out_state (out_state_w[g]),
        .busy      (busy_w[g])
      );
    end
  endgenerate

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // reference model: GF(2^8) arithmetic with the circulant matrix (2 3 1 1)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [15:0] prod;
    prod = 16'd0;
    for (int b = 0; b < 8; b++)
      if (m[b]) prod ^= (16'(a) << b);
    for (int bit_i = 15; bit_i >= 8; bit_i--)
      if (prod[bit_i]) prod ^= (16'h11b << (bit_i - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] coef(input int d);
    case (d & 3)
      0:       return 8'd2;
      1:       return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic last);
    logic [127:0] o;
    logic [7:0]   acc;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (last) acc = s[32*c + 8*r +: 8];
        else begin
          acc = 8'd0;
          for (int j = 0; j < 4; j++) acc ^= gmul(s[32*c + 8*j +: 8], coef(j - r));
        end
        o[32*c + 8*r +: 8] = acc ^ k[32*c + 8*r +: 8];
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // scoreboard and per-cycle compare against the selected instance
  always @(negedge clk) begin
    if (out_valid_w[sel]) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 128'(1), 128'(0));
      else begin
        check("out_state_vs_model", out_state_w[sel], exp_q[0]);
        if (out_ready && rst_n) void'(exp_q.pop_front());
      end
      check("in_ready_in_done", 128'(in_ready_w[sel]), 128'(0));
    end
    check("busy_vs_in_ready", 128'(busy_w[sel]), 128'(!in_ready_w[sel]));
    if (!rst_n) exp_q.delete();
    else if (in_valid[sel] && in_ready_w[sel]) exp_q.push_back(model(in_state, in_key, in_last));
  end

  // driver tasks; each starts and ends just after a rising edge
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      output int waited);
    bit ok;
    in_state = s;
    in_key = k;
    in_last = l;
    in_valid[sel] = 1'b1;
    ok = 0;
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_w[sel]) begin
        ok = 1;
        break;
      end
      waited++;
    end
    check("accept_timeout", 128'(ok), 128'(1));
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int lat);
    bit found;
    lat = 0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid_w[sel]) begin
        found = 1;
        break;
      end
    end
    check("out_valid_timeout", 128'(found), 128'(1));
  endtask

  task automatic drain();
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [127:0] s, input logic [127:0] k,
                         input logic l, input logic [127:0] lit);
    int lat, waited;
    send(s, k, l, waited);
    wait_out(lat);
    check({name, "_latency"}, 128'(lat), 128'(4 >> sel));
    check({name, "_out"}, out_state_w[sel], lit);
    drain();
    @(negedge clk);
    check({name, "_in_ready_after"}, 128'(in_ready_w[sel]), 128'(1));
    check({name, "_out_valid_after"}, 128'(out_valid_w[sel]), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, waited;
    rst_n = 1'b0;
    out_ready = 1'b0;
    in_state = 128'd0;
    in_key = 128'd0;
    in_last = 1'b0;
    for (int g = 0; g < 3; g++) in_valid[g] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_in_ready", 128'(in_ready_w[g]), 128'(1));
      check("rst_out_valid", 128'(out_valid_w[g]), 128'(0));
      check("rst_busy", 128'(busy_w[g]), 128'(0));
      check("rst_out_state", out_state_w[g], 128'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // pin the reference model to hand-computed results
    check("model_v1", model(V1_S, 128'd0, 1'b0), V1_O);
    check("model_v2", model(V2_S, 128'd0, 1'b0), V2_O);
    check("model_fips", model(FI_S, FI_K, 1'b0), FI_O);
    check("model_last", model(LA_S, ONES, 1'b1), LA_O);

    sel = 0;
    run_vec("c1_v1", V1_S, 128'd0, 1'b0, V1_O);
    run_vec("c1_v2", V2_S, 128'd0, 1'b0, V2_O);
    run_vec("c1_fips", FI_S, FI_K, 1'b0, FI_O);
    run_vec("c1_last", LA_S, ONES, 1'b1, LA_O);

    sel = 1;
    run_vec("c2_fips", FI_S, FI_K, 1'b0, FI_O);
    run_vec("c2_last", LA_S, ONES, 1'b1, LA_O);

    sel = 2;
    run_vec("c4_fips", FI_S, FI_K, 1'b0, FI_O);
    run_vec("c4_v2", V2_S, 128'd0, 1'b0, V2_O);

    // backpressure in DONE, then a back-to-back block
    sel = 0;
    send(FI_S, FI_K, 1'b0, waited);
    wait_out(lat);
    check("bp_latency", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 128'(out_valid_w[sel]), 128'(1));
      check("bp_in_ready", 128'(in_ready_w[sel]), 128'(0));
      check("bp_out_state", out_state_w[sel], FI_O);
      @(negedge clk);
    end
    drain();
    send(V2_S, 128'd0, 1'b0, waited);
    check("b2b_accept_wait", 128'(waited), 128'(0));
    wait_out(lat);
    check("b2b_latency", 128'(lat), 128'(4));
    check("b2b_out", out_state_w[sel], V2_O);
    drain();

    // reset while the column counter sits at 2
    send(FI_S, FI_K, 1'b0, waited);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid_w[sel]), 128'(0));
    check("midrst_in_ready", 128'(in_ready_w[sel]), 128'(1));
    check("midrst_out_state", out_state_w[sel], 128'd0);
    check("midrst_busy", 128'(busy_w[sel]), 128'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_no_stale_valid", 128'(out_valid_w[sel]), 128'(0));
    end
    @(posedge clk);
    #1;
    run_vec("post_rst_fips", FI_S, FI_K, 1'b0, FI_O);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
